// File: rtl/multi_cycle_control_fsm.sv
// Main control FSM for the multi-cycle MIPS core: sequences the shared ALU, memory
// port and register file across fetch/decode/execute/memory/writeback phases.
module multi_cycle_control_fsm #(
  parameter bit USE_MEM_READY = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_is_zero,
  input  logic       mem_ready,
  output logic [2:0] alu_fn,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic       pc_en,
  output logic       ir_write,
  output logic       i_or_d,
  output logic       mem_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_EXECUTE = 4'd7,
    S_ALUWB   = 4'd8,
    S_BRANCH  = 4'd9,
    S_ADDIEX  = 4'd10,
    S_ADDIWB  = 4'd11,
    S_JUMP    = 4'd12,
    S_ILLEGAL = 4'd13
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] FN_AND = 3'b000;
  localparam logic [2:0] FN_OR  = 3'b001;
  localparam logic [2:0] FN_ADD = 3'b010;
  localparam logic [2:0] FN_SUB = 3'b110;
  localparam logic [2:0] FN_SLT = 3'b111;

  state_t r_state;
  state_t w_state_next;
  logic   w_ready;
  logic   w_funct_ok;

  // With the handshake disabled every memory access completes in one cycle.
  assign w_ready    = USE_MEM_READY ? mem_ready : 1'b1;
  assign w_funct_ok = (funct == 6'h20) || (funct == 6'h22) || (funct == 6'h24) ||
                      (funct == 6'h25) || (funct == 6'h2A);
  assign state_dbg  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = S_IDLE;
    alu_fn       = FN_ADD;
    alu_src_a    = 1'b0;
    alu_src_b    = 2'b00;
    pc_src       = 2'b00;
    pc_en        = 1'b0;
    ir_write     = 1'b0;
    i_or_d       = 1'b0;
    mem_write    = 1'b0;
    reg_write    = 1'b0;
    reg_dst      = 1'b0;
    mem_to_reg   = 1'b0;
    illegal_op   = 1'b0;

    case (r_state)
      S_IDLE: w_state_next = S_FETCH;
      S_FETCH: begin
        alu_src_b    = 2'b01;
        ir_write     = w_ready;
        pc_en        = w_ready;
        w_state_next = w_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Speculatively compute the branch target into ALUOut.
        alu_src_b = 2'b11;
        case (opcode)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_RTYPE:     w_state_next = w_funct_ok ? S_EXECUTE : S_ILLEGAL;
          OP_BEQ:       w_state_next = S_BRANCH;
          OP_ADDI:      w_state_next = S_ADDIEX;
          OP_J:         w_state_next = S_JUMP;
          default:      w_state_next = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_state_next = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        i_or_d       = 1'b1;
        w_state_next = w_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        mem_to_reg   = 1'b1;
        reg_write    = 1'b1;
        w_state_next = S_FETCH;
      end
      S_MEMWR: begin
        i_or_d       = 1'b1;
        mem_write    = 1'b1;
        w_state_next = w_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        case (funct)
          6'h22:   alu_fn = FN_SUB;
          6'h24:   alu_fn = FN_AND;
          6'h25:   alu_fn = FN_OR;
          6'h2A:   alu_fn = FN_SLT;
          default: alu_fn = FN_ADD;
        endcase
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst      = 1'b1;
        reg_write    = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a    = 1'b1;
        alu_fn       = FN_SUB;
        pc_src       = 2'b01;
        pc_en        = alu_is_zero;
        w_state_next = S_FETCH;
      end
      S_ADDIEX: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        w_state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write    = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JUMP: begin
        pc_src       = 2'b10;
        pc_en        = 1'b1;
        w_state_next = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal_op   = 1'b1;
        w_state_next = S_FETCH;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multi_cycle_control_fsm.sv
// Randomized bench for multi_cycle_control_fsm: each instruction is expanded into its
// expected per-cycle phase list and every cycle's state and control word are compared.
module tb_multi_cycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       alu_is_zero;
  logic       mem_ready;
  logic [2:0] alu_fn;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] pc_src;
  logic       pc_en;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_write;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal_op;
  logic [3:0] state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    int st;
    bit rdy;
  } step_t;

  multi_cycle_control_fsm #(.USE_MEM_READY(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .funct      (funct),
    .alu_is_zero(alu_is_zero),
    .mem_ready  (mem_ready),
    .alu_fn     (alu_fn),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .pc_src     (pc_src),
    .pc_en      (pc_en),
    .ir_write   (ir_write),
    .i_or_d     (i_or_d),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  logic [15:0] w_ctrl;
  assign w_ctrl = {alu_fn, alu_src_a, alu_src_b, pc_src, pc_en, ir_write, i_or_d,
                   mem_write, reg_write, reg_dst, mem_to_reg, illegal_op};

  task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  function automatic bit funct_valid(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h22 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A;
  endfunction

  // Control word expected in a given phase, straight from the per-phase output table.
  function automatic logic [15:0] exp_ctrl(input int st, input bit rdy, input bit zero, input logic [5:0] fn);
    logic [2:0] fnc = 3'b010;
    logic a = 0, pe = 0, irw = 0, iod = 0, mw = 0, rw = 0, rd = 0, m2r = 0, ill = 0;
    logic [1:0] b = 2'b00, ps = 2'b00;
    case (st)
      1:  begin b = 2'b01; irw = rdy; pe = rdy; end
      2:  b = 2'b11;
      3:  begin a = 1; b = 2'b10; end
      4:  iod = 1;
      5:  begin m2r = 1; rw = 1; end
      6:  begin iod = 1; mw = 1; end
      7:  begin
            a = 1;
            if (fn == 6'h22) fnc = 3'b110;
            else if (fn == 6'h24) fnc = 3'b000;
            else if (fn == 6'h25) fnc = 3'b001;
            else if (fn == 6'h2A) fnc = 3'b111;
          end
      8:  begin rd = 1; rw = 1; end
      9:  begin a = 1; fnc = 3'b110; ps = 2'b01; pe = zero; end
      10: begin a = 1; b = 2'b10; end
      11: rw = 1;
      12: begin ps = 2'b10; pe = 1; end
      13: ill = 1;
      default: ;
    endcase
    return {fnc, a, b, ps, pe, irw, iod, mw, rw, rd, m2r, ill};
  endfunction

  // Phases of one instruction: a FETCH run, DECODE, then the opcode's own phases.
  // wf / wm are the number of not-ready cycles in FETCH and in the memory phase.
  task automatic run_instr(input string name, input logic [5:0] op, input logic [5:0] fn,
                           input int wf, input int wm, input int zmode);
    step_t q[$];
    bit    zero;
    bit    rdy_drv;
    for (int i = 0; i <= wf; i++) q.push_back('{1, i == wf});
    q.push_back('{2, 1'b1});
    if (op == 6'h23) begin
      q.push_back('{3, 1'b1});
      for (int i = 0; i <= wm; i++) q.push_back('{4, i == wm});
      q.push_back('{5, 1'b1});
    end else if (op == 6'h2B) begin
      q.push_back('{3, 1'b1});
      for (int i = 0; i <= wm; i++) q.push_back('{6, i == wm});
    end else if (op == 6'h00 && funct_valid(fn)) begin
      q.push_back('{7, 1'b1});
      q.push_back('{8, 1'b1});
    end else if (op == 6'h04) begin
      q.push_back('{9, 1'b1});
    end else if (op == 6'h08) begin
      q.push_back('{10, 1'b1});
      q.push_back('{11, 1'b1});
    end else if (op == 6'h02) begin
      q.push_back('{12, 1'b1});
    end else begin
      q.push_back('{13, 1'b1});
    end

    foreach (q[k]) begin
      if (q[k].st == 1 || q[k].st == 4 || q[k].st == 6) rdy_drv = q[k].rdy;
      else rdy_drv = 1'($urandom_range(0, 1));
      zero = (zmode == 2) ? 1'($urandom_range(0, 1)) : 1'(zmode);
      mem_ready   = rdy_drv;
      alu_is_zero = zero;
      // The decode fields only matter in the phases that look at them; scramble them elsewhere.
      if (q[k].st == 2 || q[k].st == 3 || q[k].st == 7) begin
        opcode = op;
        funct  = fn;
      end else begin
        opcode = 6'($urandom_range(0, 63));
        funct  = 6'($urandom_range(0, 63));
      end
      @(negedge clk);
      check_val($sformatf("%s_state%0d", name, k), 32'(state_dbg), 32'(q[k].st));
      check_val($sformatf("%s_ctrl%0d", name, k), 32'(w_ctrl), 32'(exp_ctrl(q[k].st, rdy_drv, zero, fn)));
      @(posedge clk);
      #1;
    end
    $display("instr %-8s op=%02h fn=%02h waits=%0d/%0d cycles=%0d", name, op, fn, wf, wm, q.size());
  endtask

  logic [5:0] good_fn [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};

  initial begin
    logic [5:0] op;
    logic [5:0] fn;
    int         kind;
    rst_n = 1'b0; opcode = 6'h23; funct = 6'h20; alu_is_zero = 1'b1; mem_ready = 1'b1;
    #12;
    check_val("reset_state", 32'(state_dbg), 32'd0);
    check_val("reset_ctrl", 32'(w_ctrl), 32'h4000);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_val("release_idle", 32'(state_dbg), 32'd0);
    @(posedge clk);
    #1;
    $display("reset released, entering FETCH");

    run_instr("lw", 6'h23, 6'h11, 0, 0, 2);
    run_instr("slt", 6'h00, 6'h2A, 0, 0, 2);
    run_instr("beq_t", 6'h04, 6'h00, 0, 0, 1);
    run_instr("beq_nt", 6'h04, 6'h00, 0, 0, 0);
    run_instr("sw_wait", 6'h2B, 6'h00, 0, 3, 2);
    run_instr("ill_op", 6'h3F, 6'h20, 0, 0, 2);
    run_instr("ill_fn", 6'h00, 6'h03, 0, 0, 2);
    run_instr("addi", 6'h08, 6'h00, 1, 0, 2);
    run_instr("j", 6'h02, 6'h00, 2, 0, 2);

    for (int n = 0; n < 200; n++) begin
      kind = int'($urandom_range(0, 7));
      fn = 6'($urandom_range(0, 63));
      case (kind)
        0: op = 6'h23;
        1: op = 6'h2B;
        2: begin op = 6'h00; fn = good_fn[$urandom_range(0, 4)]; end
        3: begin op = 6'h00; while (funct_valid(fn)) fn = 6'($urandom_range(0, 63)); end
        4: op = 6'h04;
        5: op = 6'h08;
        6: op = 6'h02;
        default: begin
          op = 6'($urandom_range(0, 63));
          while (op == 6'h00 || op == 6'h02 || op == 6'h04 || op == 6'h08 || op == 6'h23 || op == 6'h2B)
            op = 6'($urandom_range(0, 63));
        end
      endcase
      run_instr($sformatf("rnd%0d", n), op, fn, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)), 2);
    end

    // Asynchronous reset while a store is stalled in MEMWR.
    mem_ready = 1'b1; opcode = 6'h2B; funct = 6'h00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    @(posedge clk); #1;
    check_val("memwr_state", 32'(state_dbg), 32'd6);
    check_val("memwr_write", 32'(mem_write), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    check_val("async_rst_state", 32'(state_dbg), 32'd0);
    check_val("async_rst_write", 32'(mem_write), 32'd0);
    check_val("async_rst_ctrl", 32'(w_ctrl), 32'h4000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("rerelease_idle", 32'(state_dbg), 32'd0);
    @(posedge clk); #1;
    check_val("rerelease_fetch", 32'(state_dbg), 32'd1);
    $display("async reset mid-MEMWR done");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
